// File: rtl/size_exploration_sequencer_pkg.sv
// Shared types and defaults for the size-exploration sequencer.
// Holds the FSM state encoding, default sizing and the counter width helper.
package size_exploration_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_NUM_OPERANDS = 3;
  localparam int DEF_TIMEOUT      = 16;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/size_exploration_sequencer_if.sv
// Pad-side and unit-side signal bundle of the sequencer.
// master = pin wrapper / unit side, slave = the sequencer itself.
interface size_exploration_sequencer_if #(
  parameter int WIDTH        = size_exploration_pkg::DEF_WIDTH,
  parameter int NUM_OPERANDS = size_exploration_pkg::DEF_NUM_OPERANDS,
  parameter int TIMEOUT      = size_exploration_pkg::DEF_TIMEOUT
);
  localparam int CW = size_exploration_pkg::cnt_w(TIMEOUT);

  logic [NUM_OPERANDS-1:0]       serial_in;
  logic                          load_en;
  logic                          start;
  logic [NUM_OPERANDS*WIDTH-1:0] operands;
  logic                          dut_start;
  logic                          dut_done;
  logic [WIDTH-1:0]              dut_result;
  logic                          loaded;
  logic                          busy;
  logic                          result_valid;
  logic                          timeout;
  logic [CW-1:0]                 cycles_taken;
  logic [1:0]                    byte_sel;
  logic [7:0]                    byte_out;

  modport master (
    output serial_in, load_en, start, dut_done, dut_result, byte_sel,
    input  operands, dut_start, loaded, busy, result_valid, timeout,
           cycles_taken, byte_out
  );

  modport slave (
    input  serial_in, load_en, start, dut_done, dut_result, byte_sel,
    output operands, dut_start, loaded, busy, result_valid, timeout,
           cycles_taken, byte_out
  );

endinterface

// File: rtl/size_exploration_sequencer_serial_operand_loader.sv
// MSB-first serial operand shift registers with a saturating bit counter.
// clear resets only the counter; operand contents survive a clear.
module serial_operand_loader
  import size_exploration_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int NUM_OPERANDS = DEF_NUM_OPERANDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift_en_i,
  input  logic                          clear_i,
  input  logic [NUM_OPERANDS-1:0]       serial_in_i,
  output logic [NUM_OPERANDS*WIDTH-1:0] operands_o,
  output logic                          loaded_o
);
  localparam int BW = cnt_w(WIDTH);

  logic [NUM_OPERANDS*WIDTH-1:0] ops_q, ops_d;
  logic [BW-1:0]                 bits_q, bits_d;

  always_comb begin
    ops_d  = ops_q;
    bits_d = bits_q;
    if (clear_i) begin
      bits_d = '0;
    end else if (shift_en_i) begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        ops_d[WIDTH*i +: WIDTH] = {ops_q[WIDTH*i +: WIDTH-1], serial_in_i[i]};
      end
      // Saturate so loaded stays up while older bits fall off the top.
      if (bits_q != BW'(WIDTH)) begin
        bits_d = bits_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q  <= '0;
      bits_q <= '0;
    end else begin
      ops_q  <= ops_d;
      bits_q <= bits_d;
    end
  end

  assign operands_o = ops_q;
  assign loaded_o   = (bits_q == BW'(WIDTH));

endmodule

// File: rtl/size_exploration_sequencer.sv
// Run controller: serial operand load, one-cycle start pulse, wait for done
// or timeout, then hold the captured result for byte-wise readout on the pads.
module size_exploration_sequencer
  import size_exploration_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int NUM_OPERANDS = DEF_NUM_OPERANDS,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  size_exploration_sequencer_if.slave  sif
);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int PW = (WIDTH < 32) ? 32 : WIDTH;

  state_e           state_q, state_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic [TW-1:0]    cycles_q, cycles_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             shift_en, clear;
  logic [PW-1:0]    res_pad;

  serial_operand_loader #(
    .WIDTH        (WIDTH),
    .NUM_OPERANDS (NUM_OPERANDS)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .shift_en_i  (shift_en),
    .clear_i     (clear),
    .serial_in_i (sif.serial_in),
    .operands_o  (sif.operands),
    .loaded_o    (sif.loaded)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cycles_d  = cycles_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    shift_en  = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // start outranks load_en, so no shift happens on the launch cycle.
        if (sif.start) begin
          state_d   = ISSUE;
          clear     = 1'b1;
          timeout_d = 1'b0;
          wcnt_d    = '0;
        end else if (sif.load_en) begin
          state_d  = IDLE;
          shift_en = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        wcnt_d = wcnt_q + TW'(1);
        if (sif.dut_done) begin
          result_d = sif.dut_result;
          cycles_d = wcnt_q + TW'(1);
          state_d  = DONE;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          result_d  = '0;
          timeout_d = 1'b1;
          cycles_d  = TW'(TIMEOUT);
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      cycles_q  <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cycles_q  <= cycles_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  // Status is decoded from the state register so reset clears it at once.
  assign sif.dut_start    = (state_q == ISSUE);
  assign sif.busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign sif.result_valid = (state_q == DONE);
  assign sif.timeout      = timeout_q;
  assign sif.cycles_taken = cycles_q;

  assign res_pad      = PW'(result_q);
  assign sif.byte_out = res_pad[{sif.byte_sel, 3'b000} +: 8];

endmodule
